// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-port arbiter of the dual-port I/D memory.
// Requester 0 is the CPU data path; requester 1 is the auxiliary master (DMA / loader).
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } owner_e;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_AUX = 1'b1;

  localparam int DWIDTH_DFLT = 32;
  localparam int BE_W        = DWIDTH_DFLT / 8;

  function automatic owner_e owner_of(input logic id);
    return (id == ID_AUX) ? OWN_1 : OWN_0;
  endfunction

endpackage

// File: rtl/dmem_rd_tracker.sv
// Remembers which requester issued last cycle's read and steers the
// one-cycle-latency memory read data back to that requester only.
module dmem_rd_tracker
  import dmem_arb_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   rd_issue,
  input  logic                   rd_issue_id,
  input  logic [DWIDTH-1:0]      mem_rdata,
  output logic [1:0]             rvalid,
  output logic [1:0][DWIDTH-1:0] rdata
);

  logic rd_pend_reg;
  logic rd_id_reg;

  // Async reset drops a pending return immediately, even mid-cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_pend_reg <= 1'b0;
      rd_id_reg   <= ID_CPU;
    end else begin
      rd_pend_reg <= rd_issue;
      if (rd_issue) begin
        rd_id_reg <= rd_issue_id;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign rvalid[gi] = rd_pend_reg && (rd_id_reg == 1'(gi));
      assign rdata[gi]  = rvalid[gi] ? mem_rdata : '0;
    end
  endgenerate

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for memory port 2: combinational same-cycle grant,
// round robin on ties, bounded lock bursts, and read-data return routing.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AWIDTH    = 14,
  parameter int DWIDTH    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic                  m0_lock,
  input  logic [31:0]           m0_addr,
  input  logic [DWIDTH/8-1:0]   m0_be,
  input  logic [DWIDTH-1:0]     m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DWIDTH-1:0]     m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic                  m1_lock,
  input  logic [31:0]           m1_addr,
  input  logic [DWIDTH/8-1:0]   m1_be,
  input  logic [DWIDTH-1:0]     m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DWIDTH-1:0]     m1_rdata,
  output logic [AWIDTH-1:0]     mem_addr,
  output logic [DWIDTH/8-1:0]   mem_be,
  output logic [DWIDTH-1:0]     mem_wdata,
  output logic                  mem_we,
  input  logic [DWIDTH-1:0]     mem_rdata
);

  localparam logic [7:0] MAX_B = 8'(MAX_BURST);

  owner_e     owner_reg, owner_next;
  logic       last_gnt_reg, last_gnt_next;
  logic [7:0] burst_cnt_reg, burst_cnt_next;

  logic                gnt_any;
  logic                gnt_id;
  logic                sel_we;
  logic                sel_lock;
  logic [31:0]         sel_addr;
  logic [DWIDTH/8-1:0] sel_be;
  logic [DWIDTH-1:0]   sel_wdata;
  logic                other_req;
  logic                unused_addr_bits;

  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = ID_CPU;
    if (n_rst) begin
      case ({m1_req, m0_req})
        2'b01: begin
          gnt_any = 1'b1;
          gnt_id  = ID_CPU;
        end
        2'b10: begin
          gnt_any = 1'b1;
          gnt_id  = ID_AUX;
        end
        2'b11: begin
          gnt_any = 1'b1;
          // A locked owner keeps the port until its burst budget runs out.
          if (owner_reg != OWN_NONE && burst_cnt_reg < MAX_B) begin
            gnt_id = (owner_reg == OWN_1) ? ID_AUX : ID_CPU;
          end else begin
            gnt_id = ~last_gnt_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign sel_we    = (gnt_id == ID_AUX) ? m1_we    : m0_we;
  assign sel_lock  = (gnt_id == ID_AUX) ? m1_lock  : m0_lock;
  assign sel_addr  = (gnt_id == ID_AUX) ? m1_addr  : m0_addr;
  assign sel_be    = (gnt_id == ID_AUX) ? m1_be    : m0_be;
  assign sel_wdata = (gnt_id == ID_AUX) ? m1_wdata : m0_wdata;
  assign other_req = (gnt_id == ID_AUX) ? m0_req   : m1_req;

  assign unused_addr_bits = ^{sel_addr[31:AWIDTH+2], sel_addr[1:0]};

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      owner_reg     <= OWN_NONE;
      last_gnt_reg  <= ID_AUX;
      burst_cnt_reg <= '0;
    end else begin
      owner_reg     <= owner_next;
      last_gnt_reg  <= last_gnt_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  always_comb begin
    owner_next     = OWN_NONE;
    burst_cnt_next = burst_cnt_reg;
    last_gnt_next  = last_gnt_reg;
    if (gnt_any && sel_lock) begin
      owner_next = owner_of(gnt_id);
    end
    if (gnt_any) begin
      last_gnt_next = gnt_id;
    end
    // The count only measures how long the other side has been kept waiting.
    if (owner_next != owner_reg) begin
      burst_cnt_next = '0;
    end else if (gnt_any && owner_reg == owner_of(gnt_id) && other_req &&
                 burst_cnt_reg < MAX_B) begin
      burst_cnt_next = burst_cnt_reg + 8'd1;
    end
  end

  always_comb begin
    m0_gnt    = gnt_any && (gnt_id == ID_CPU);
    m1_gnt    = gnt_any && (gnt_id == ID_AUX);
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any) begin
      mem_we    = sel_we;
      mem_be    = sel_be;
      mem_addr  = sel_addr[AWIDTH+1:2];
      mem_wdata = sel_wdata;
    end
  end

  logic [1:0]             rd_valid;
  logic [1:0][DWIDTH-1:0] rd_data;

  dmem_rd_tracker #(
    .DWIDTH (DWIDTH)
  ) u_rd_tracker (
    .clk         (clk),
    .n_rst       (n_rst),
    .rd_issue    (gnt_any && !sel_we),
    .rd_issue_id (gnt_id),
    .mem_rdata   (mem_rdata),
    .rvalid      (rd_valid),
    .rdata       (rd_data)
  );

  assign m0_rvalid = rd_valid[0];
  assign m1_rvalid = rd_valid[1];
  assign m0_rdata  = rd_data[0];
  assign m1_rdata  = rd_data[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed plus random bench for dmem_port_arbiter against a rule-level model
// with its own shadow copy of memory contents.
module tb_dmem_port_arbiter;

  localparam int MAXB = 3;

  typedef struct {
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } rq_t;

  logic        clk = 1'b0;
  logic        n_rst;
  rq_t         rq [2];
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [13:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  assign m0_req = rq[0].req;  assign m0_we = rq[0].we;  assign m0_lock = rq[0].lock;
  assign m0_addr = rq[0].addr; assign m0_be = rq[0].be; assign m0_wdata = rq[0].wdata;
  assign m1_req = rq[1].req;  assign m1_we = rq[1].we;  assign m1_lock = rq[1].lock;
  assign m1_addr = rq[1].addr; assign m1_be = rq[1].be; assign m1_wdata = rq[1].wdata;

  dmem_port_arbiter #(.AWIDTH(14), .DWIDTH(32), .MAX_BURST(MAXB)) dut (
    .clk(clk), .n_rst(n_rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_pat(input int w);
    return 32'hA500_0000 ^ (32'(w) * 32'h0001_3579);
  endfunction

  // Synchronous memory seen by port 2, plus a preload path for directed data.
  bit [31:0]   env_mem [256];
  bit          env_wr  [256];
  logic        pl_en = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  function automatic logic [31:0] env_rd(input logic [7:0] a);
    return env_wr[a] ? env_mem[a] : init_pat(int'(a));
  endfunction

  always @(posedge clk) begin
    logic [31:0] cur;
    if (pl_en) begin
      env_mem[pl_addr] = pl_data;
      env_wr[pl_addr]  = 1'b1;
    end
    if (mem_we) begin
      cur = env_rd(mem_addr[7:0]);
      for (int b = 0; b < 4; b++) if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
      env_mem[mem_addr[7:0]] = cur;
      env_wr[mem_addr[7:0]]  = 1'b1;
    end
    mem_rdata <= env_rd(mem_addr[7:0]);
  end

  // Reference model state: owner -1 means nobody holds the lock.
  int          m_owner, m_last, m_cnt, m_rdid, last_g;
  logic        m_rdv;
  logic [31:0] m_rddata;
  logic [31:0] shadow [256];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask

  function automatic rq_t mk(input logic req, input logic we, input logic lock,
                             input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata);
    rq_t r;
    r.req = req; r.we = we; r.lock = lock; r.addr = addr; r.be = be; r.wdata = wdata;
    return r;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_cnt = 0; m_rdv = 1'b0; m_rdid = 0; m_rddata = '0;
  endtask

  function automatic int pick();
    if (!rq[0].req && !rq[1].req) return -1;
    if (rq[0].req != rq[1].req) return rq[0].req ? 0 : 1;
    if (m_owner >= 0 && m_cnt < MAXB) return m_owner;
    return 1 - m_last;
  endfunction

  task automatic model_update(input int g);
    int          nown;
    int          idx;
    logic [31:0] w;
    nown = (g >= 0 && rq[g].lock) ? g : -1;
    if (nown != m_owner) m_cnt = 0;
    else if (g >= 0 && g == m_owner && rq[1-g].req) m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
    m_owner = nown;
    m_rdv = 1'b0;
    if (g >= 0) begin
      m_last = g;
      idx = int'(rq[g].addr[9:2]);
      if (rq[g].we) begin
        w = shadow[idx];
        for (int b = 0; b < 4; b++) if (rq[g].be[b]) w[8*b +: 8] = rq[g].wdata[8*b +: 8];
        shadow[idx] = w;
      end else begin
        m_rdv = 1'b1; m_rdid = g; m_rddata = shadow[idx];
      end
    end
  endtask

  // One cycle: called just after a negedge with inputs already set.
  task automatic step(input int exp_g);
    int          g;
    logic        rv0, rv1;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    logic        e_we;
    #1;
    g = pick();
    if (exp_g != -2) chk("dir_gnt", {30'd0, m1_gnt, m0_gnt}, (exp_g < 0) ? 32'd0 : 32'd1 << exp_g);
    chk("m0_gnt", 32'(m0_gnt), 32'(g == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(g == 1));
    e_we = 1'b0; e_be = '0; e_addr = '0; e_wd = '0;
    if (g >= 0) begin
      e_we = rq[g].we; e_be = rq[g].be; e_addr = 32'(rq[g].addr[15:2]); e_wd = rq[g].wdata;
    end
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_be", 32'(mem_be), 32'(e_be));
    chk("mem_addr", 32'(mem_addr), e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    rv0 = m_rdv && m_rdid == 0;
    rv1 = m_rdv && m_rdid == 1;
    chk("m0_rvalid", 32'(m0_rvalid), 32'(rv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(rv1));
    chk("m0_rdata", m0_rdata, rv0 ? m_rddata : 32'd0);
    chk("m1_rdata", m1_rdata, rv1 ? m_rddata : 32'd0);
    $display("cyc t=%0t req=%b%b gnt=%b%b model_g=%0d rv=%b%b", $time, m1_req, m0_req,
             m1_gnt, m0_gnt, g, m1_rvalid, m0_rvalid);
    @(posedge clk);
    model_update(g);
    last_g = g;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] exp_rb;
    rq_t idle;
    idle = mk(1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    for (int i = 0; i < 256; i++) shadow[i] = init_pat(i);
    shadow[4] = 32'hDEAD_BEEF;
    model_reset();
    last_g = -1;
    n_rst = 1'b0;
    rq[0] = mk(1'b1, 1'b0, 1'b1, 32'h10, 4'hF, 32'd0);
    rq[1] = mk(1'b1, 1'b0, 1'b1, 32'h20, 4'hF, 32'd0);
    pl_en = 1'b1; pl_addr = 8'd4; pl_data = 32'hDEAD_BEEF;
    @(negedge clk);
    pl_en = 1'b0;
    #1;
    chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    // Tie after reset: round robin starting with m0.
    rq[0] = mk(1'b1, 1'b0, 1'b0, 32'h20, 4'hF, 32'd0);
    rq[1] = mk(1'b1, 1'b0, 1'b0, 32'h30, 4'hF, 32'd0);
    step(0); step(1); step(0); step(1);
    rq[0] = idle; rq[1] = idle;
    step(-1);

    // Solo read of preloaded word 4.
    rq[0] = mk(1'b1, 1'b0, 1'b0, 32'h10, 4'hF, 32'd0);
    #1 chk("solo_addr", 32'(mem_addr), 32'd4);
    step(0);
    rq[0] = idle;
    chk("solo_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("solo_m1_rv", 32'(m1_rvalid), 32'd0);
    step(-1);

    // Burst: m1 already owns the port when m0 starts waiting.
    rq[1] = mk(1'b1, 1'b1, 1'b1, 32'h80, 4'hF, 32'hCAFE_0001);
    step(1);
    rq[0] = mk(1'b1, 1'b0, 1'b0, 32'h24, 4'hF, 32'd0);
    step(1); step(1); step(1); step(0); step(1);
    rq[0] = idle; rq[1] = idle;
    step(-1);

    // Lone requester overrides a lock held by an owner that drops req.
    rq[0] = mk(1'b1, 1'b0, 1'b1, 32'h14, 4'hF, 32'd0);
    step(0);
    rq[0] = idle;
    rq[1] = mk(1'b1, 1'b0, 1'b0, 32'h18, 4'hF, 32'd0);
    step(1);
    rq[1] = idle;
    step(-1);

    // Partial write then readback of word 16.
    rq[1] = mk(1'b1, 1'b1, 1'b0, 32'h40, 4'b0011, 32'h1234_5678);
    #1;
    chk("wr_mem_we", 32'(mem_we), 32'd1);
    chk("wr_mem_be", 32'(mem_be), 32'h3);
    chk("wr_mem_addr", 32'(mem_addr), 32'd16);
    step(1);
    chk("wr_no_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    rq[1] = mk(1'b1, 1'b0, 1'b0, 32'h40, 4'hF, 32'd0);
    step(1);
    rq[1] = idle;
    exp_rb = init_pat(16);
    exp_rb[15:0] = 16'h5678;
    chk("wr_readback", m1_rdata, exp_rb);
    step(-1);

    // Reset while a read return is in flight.
    rq[0] = mk(1'b1, 1'b0, 1'b0, 32'h10, 4'hF, 32'd0);
    step(0);
    chk("mid_rv_pre", 32'(m0_rvalid), 32'd1);
    rq[1] = mk(1'b1, 1'b0, 1'b0, 32'h30, 4'hF, 32'd0);
    n_rst = 1'b0;
    #1;
    chk("mid_rv_drop", 32'(m0_rvalid), 32'd0);
    chk("mid_rdata", m0_rdata, 32'd0);
    chk("mid_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    step(0);
    rq[0] = idle; rq[1] = idle;
    step(-1);

    // Random traffic; an ungranted request holds its fields.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(rq[i].req && last_g != i)) begin
          rq[i] = mk($urandom_range(0, 99) < 65, 1'($urandom), $urandom_range(0, 99) < 55,
                     {16'($urandom), 6'd0, 8'($urandom_range(0, 31)), 2'($urandom)},
                     4'($urandom), $urandom);
        end
      end
      step(-2);
    end
    rq[0] = idle; rq[1] = idle;
    step(-1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
